// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter operation encoding.
// Functions work on a fixed-width word; callers zero-extend and truncate to their WIDTH.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 64;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_LOAD,
    CNT_UP,
    CNT_DOWN
  } cnt_op_e;

  function automatic gray_word_t bin_to_gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Leading zero-extension bits decode to zero, so any narrower width truncates cleanly.
  function automatic gray_word_t gray_to_bin(input gray_word_t gray);
    gray_word_t bin;
    bin = '0;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int unsigned i = 1; i < GRAY_MAX_W; i++) begin
      bin[GRAY_MAX_W-1-i] = bin[GRAY_MAX_W-i] ^ gray[GRAY_MAX_W-1-i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_decode.sv
// Combinational Gray-to-binary prefix-XOR chain, MSB downward.
module gray2bin_decode #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      bin[WIDTH-1-i] = bin[WIDTH-i] ^ gray[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with parallel load and wrap pulse, plus an
// independent registered Gray-to-binary decode channel.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_in_valid,
  output logic [WIDTH-1:0] bin_dec,
  output logic             bin_dec_valid
);

  cnt_op_e          op;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_wrap;
  logic [WIDTH-1:0] dec_bin;

  always_comb begin
    op = CNT_HOLD;
    if (load) begin
      op = CNT_LOAD;
    end else if (en) begin
      op = up ? CNT_UP : CNT_DOWN;
    end
  end

  always_comb begin
    next_bin  = bin_out;
    next_wrap = 1'b0;
    unique case (op)
      CNT_LOAD: next_bin = load_bin;
      CNT_UP: begin
        next_bin  = bin_out + WIDTH'(1);
        next_wrap = (bin_out == '1);
      end
      CNT_DOWN: begin
        next_bin  = bin_out - WIDTH'(1);
        next_wrap = (bin_out == '0);
      end
      default: ;
    endcase
    // Encoded from the next-state value so gray_out and bin_out update together.
    next_gray = WIDTH'(bin_to_gray(GRAY_MAX_W'(next_bin)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out  <= '0;
      gray_out <= '0;
      wrap     <= 1'b0;
    end else begin
      bin_out  <= next_bin;
      gray_out <= next_gray;
      wrap     <= next_wrap;
    end
  end

  gray2bin_decode #(.WIDTH(WIDTH)) u_decode (
    .gray (gray_in),
    .bin  (dec_bin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_dec       <= '0;
      bin_dec_valid <= 1'b0;
    end else begin
      bin_dec_valid <= gray_in_valid;
      if (gray_in_valid) begin
        bin_dec <= dec_bin;
      end
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: directed vectors push expected results,
// monitors pop and compare one cycle after each edge.
module tb_gray_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit instance
  logic       rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0, gv = 1'b0;
  logic [3:0] lb = '0, gi = '0;
  logic [3:0] bin_out, gray_out, bin_dec;
  logic       wrap, bin_dec_valid;

  gray_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(lb),
    .bin_out(bin_out), .gray_out(gray_out), .wrap(wrap),
    .gray_in(gi), .gray_in_valid(gv), .bin_dec(bin_dec), .bin_dec_valid(bin_dec_valid)
  );

  // 8-bit instance for the width sweep
  logic       rst8 = 1'b1, en8 = 1'b0, up8 = 1'b1, load8 = 1'b0, gv8 = 1'b0;
  logic [7:0] lb8 = '0, gi8 = '0;
  logic [7:0] bin8, gray8, dec8;
  logic       wrap8, dec8_valid;

  gray_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .up(up8), .load(load8), .load_bin(lb8),
    .bin_out(bin8), .gray_out(gray8), .wrap(wrap8),
    .gray_in(gi8), .gray_in_valid(gv8), .bin_dec(dec8), .bin_dec_valid(dec8_valid)
  );

  typedef struct {
    logic [3:0] bin;
    logic [3:0] gray;
    logic       wrap;
    logic [3:0] dec;
    logic       dec_v;
    logic       step;
    string      name;
  } exp4_t;

  typedef struct {
    logic [7:0] bin;
    logic [7:0] gray;
    logic       wrap;
    logic       step;
  } exp8_t;

  exp4_t q4[$];
  exp8_t q8[$];

  int errors = 0;
  int checks = 0;
  int wraps8 = 0;

  // Hand-written 4-bit Gray sequence indexed by binary count.
  logic [3:0] g4 [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                          4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] lbv, input logic [3:0] giv, input logic gvv,
                       input logic [3:0] eb, input logic [3:0] eg, input logic ew,
                       input logic [3:0] ed, input logic edv, input logic st,
                       input string nm);
    exp4_t x;
    @(negedge clk);
    rst = r; en = e; up = u; load = l; lb = lbv; gi = giv; gv = gvv;
    x.bin = eb; x.gray = eg; x.wrap = ew; x.dec = ed; x.dec_v = edv; x.step = st; x.name = nm;
    q4.push_back(x);
  endtask

  task automatic drive8(input logic r, input logic e, input logic [7:0] eb,
                        input logic [7:0] eg, input logic ew, input logic st);
    exp8_t x;
    @(negedge clk);
    rst8 = r; en8 = e;
    x.bin = eb; x.gray = eg; x.wrap = ew; x.step = st;
    q8.push_back(x);
  endtask

  logic [3:0] prev_gray4 = '0;
  always @(posedge clk) begin
    exp4_t x;
    #1;
    if (q4.size() > 0) begin
      x = q4.pop_front();
      chk({x.name, " bin_out"}, 32'(bin_out), 32'(x.bin));
      chk({x.name, " gray_out"}, 32'(gray_out), 32'(x.gray));
      chk({x.name, " wrap"}, 32'(wrap), 32'(x.wrap));
      chk({x.name, " bin_dec_valid"}, 32'(bin_dec_valid), 32'(x.dec_v));
      chk({x.name, " bin_dec"}, 32'(bin_dec), 32'(x.dec));
      if (x.step) chk({x.name, " gray one-bit"}, 32'($countones(gray_out ^ prev_gray4)), 32'd1);
      prev_gray4 = gray_out;
    end
  end

  logic [7:0] prev_gray8 = '0;
  always @(posedge clk) begin
    exp8_t x;
    #1;
    if (q8.size() > 0) begin
      x = q8.pop_front();
      chk("w8 bin_out", 32'(bin8), 32'(x.bin));
      chk("w8 gray_out", 32'(gray8), 32'(x.gray));
      chk("w8 wrap", 32'(wrap8), 32'(x.wrap));
      if (x.step) chk("w8 gray one-bit", 32'($countones(gray8 ^ prev_gray8)), 32'd1);
      if (wrap8) wraps8++;
      prev_gray8 = gray8;
    end
  end

  initial begin
    // reset, including an enabled count request held off by reset
    drive(1, 0, 0, 0, 4'd0, 4'd0, 0,  4'd0, 4'h0, 0, 4'd0, 0, 0, "reset0");
    drive(1, 1, 1, 0, 4'd0, 4'd0, 0,  4'd0, 4'h0, 0, 4'd0, 0, 0, "reset1");
    for (int k = 1; k <= 16; k++) begin
      drive(0, 1, 1, 0, 4'd0, 4'd0, 0, 4'(k), g4[k % 16], (k == 16), 4'd0, 0, 1, "count_up");
    end
    // down wrap
    drive(0, 1, 0, 0, 4'd0, 4'd0, 0,  4'd15, 4'h8, 1, 4'd0, 0, 1, "down_wrap");
    drive(0, 1, 0, 0, 4'd0, 4'd0, 0,  4'd14, 4'h9, 0, 4'd0, 0, 1, "down_after");
    // load priority and no wrap on load
    drive(0, 1, 1, 1, 4'd10, 4'd0, 0, 4'd10, 4'hF, 0, 4'd0, 0, 0, "load10_en");
    drive(0, 0, 0, 1, 4'd15, 4'd0, 0, 4'd15, 4'h8, 0, 4'd0, 0, 0, "load15");
    drive(0, 1, 1, 1, 4'd0, 4'd0, 0,  4'd0, 4'h0, 0, 4'd0, 0, 0, "load0_from15");
    drive(0, 1, 0, 1, 4'd15, 4'd0, 0, 4'd15, 4'h8, 0, 4'd0, 0, 0, "load15_from0");
    // hold, with direction toggling while disabled
    drive(0, 0, 1, 0, 4'd0, 4'd0, 0,  4'd15, 4'h8, 0, 4'd0, 0, 0, "hold");
    drive(0, 0, 0, 0, 4'd0, 4'd0, 0,  4'd15, 4'h8, 0, 4'd0, 0, 0, "hold");
    drive(0, 0, 1, 0, 4'd0, 4'd0, 0,  4'd15, 4'h8, 0, 4'd0, 0, 0, "hold");
    // direction changes between consecutive enabled edges
    drive(0, 1, 1, 0, 4'd0, 4'd0, 0,  4'd0, 4'h0, 1, 4'd0, 0, 1, "toggle_up");
    drive(0, 1, 0, 0, 4'd0, 4'd0, 0,  4'd15, 4'h8, 1, 4'd0, 0, 1, "toggle_down");
    drive(0, 1, 1, 0, 4'd0, 4'd0, 0,  4'd0, 4'h0, 1, 4'd0, 0, 1, "toggle_up2");
    // decode stream, then hold of last decoded value
    drive(0, 0, 1, 0, 4'd0, 4'hC, 1,  4'd0, 4'h0, 0, 4'd8, 1, 0, "dec_C");
    drive(0, 0, 1, 0, 4'd0, 4'h7, 1,  4'd0, 4'h0, 0, 4'd5, 1, 0, "dec_7");
    drive(0, 0, 1, 0, 4'd0, 4'h8, 1,  4'd0, 4'h0, 0, 4'd15, 1, 0, "dec_8");
    drive(0, 0, 1, 0, 4'd0, 4'h3, 0,  4'd0, 4'h0, 0, 4'd15, 0, 0, "dec_hold");
    drive(0, 0, 1, 0, 4'd0, 4'h5, 0,  4'd0, 4'h0, 0, 4'd15, 0, 0, "dec_hold");
    // reset while counting at 9 with a decode in flight
    drive(0, 0, 1, 1, 4'd8, 4'd0, 0,  4'd8, 4'hC, 0, 4'd15, 0, 0, "load8");
    drive(0, 1, 1, 0, 4'd0, 4'hC, 1,  4'd9, 4'hD, 0, 4'd8, 1, 1, "count9_dec");
    drive(1, 1, 1, 0, 4'd0, 4'h7, 1,  4'd0, 4'h0, 0, 4'd0, 0, 0, "mid_reset");
    drive(0, 1, 1, 0, 4'd0, 4'd0, 0,  4'd1, 4'h1, 0, 4'd0, 0, 1, "post_reset");
    @(negedge clk);
    en = 1'b0;

    // 8-bit width sweep: full up-count through one wrap
    drive8(1, 0, 8'd0, 8'd0, 0, 0);
    drive8(1, 0, 8'd0, 8'd0, 0, 0);
    for (int k = 1; k <= 256; k++) begin
      logic [7:0] b;
      b = 8'(k);
      drive8(0, 1, b, b ^ (b >> 1), (k == 256), 1);
    end
    @(negedge clk);
    en8 = 1'b0;

    for (int i = 0; i < 10 && (q4.size() + q8.size()) > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(q4.size() + q8.size()), 32'd0);
    chk("w8 wrap count", 32'(wraps8), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised Gray-code counter with an integrated Gray-to-binary decode channel. It is the next generation of the team's fixed 4-bit combinational binary-to-Gray converter: generalised to `WIDTH` bits, made sequential (up/down, enable, parallel load, wrap flag), and given the reverse conversion. It sits in the ALU datapath as a clean-crossing pointer/sequence source, and decodes Gray values arriving from other blocks.

## Interface

**Parameters**
- `WIDTH`, default 4: counter and code width in bits; must be ≥ 2.

**Ports**
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `en`, in, 1: count enable.
- `up`, in, 1: direction; 1 = increment, 0 = decrement.
- `load`, in, 1: parallel load strobe.
- `load_bin`, in, `WIDTH`: binary value to load.
- `bin_out`, out, `WIDTH`: registered binary count.
- `gray_out`, out, `WIDTH`: registered Gray code of the count.
- `wrap`, out, 1: one-cycle pulse on modular wrap.
- `gray_in`, in, `WIDTH`: Gray value to decode.
- `gray_in_valid`, in, 1: `gray_in` is valid this cycle.
- `bin_dec`, out, `WIDTH`: registered binary decode of `gray_in`.
- `bin_dec_valid`, out, 1: `bin_dec` is valid.

## Operation

- **Reset.** While `rst`=1 at a clock edge: `bin_out`=0, `gray_out`=0, `wrap`=0, `bin_dec`=0, `bin_dec_valid`=0. Reset overrides every other input, including mid-count and mid-load.
- **Counter priority** (per edge, `rst`=0):
  1. `load`=1 → count := `load_bin`; `wrap`=0. Load wins over `en`.
  2. else if `en`=1 and `up`=1 → count := (count + 1) mod 2^`WIDTH`.
  3. else if `en`=1 and `up`=0 → count := (count − 1) mod 2^`WIDTH`.
  4. else → hold; `wrap`=0.
- **Wrap rule.** `wrap`=1 in the cycle after an edge where either:
  - counting up from all-ones to 0, or
  - counting down from 0 to all-ones.
  
  Otherwise `wrap`=0. `wrap` never asserts on a load, even when `load_bin` is 0 or all-ones.
- **Gray encoding.** `gray_out` = count XOR (count >> 1), bit-for-bit. The MSB equals the binary MSB. `gray_out` is registered from the next-state value, so `gray_out` and `bin_out` are always coherent in the same cycle; it is never a combinational function of the `bin_out` register.
- **Single-bit property.** While enabled and not loading, successive `gray_out` values differ in exactly one bit, including across wrap.
- **Decode channel.** Independent of the counter.
  - `bin_dec[WIDTH-1]` = `gray_in[WIDTH-1]`.
  - `bin_dec[i]` = `bin_dec[i+1]` XOR `gray_in[i]`.
  - Registered; `bin_dec_valid` follows `gray_in_valid` by one cycle.
  - `bin_dec` holds its last value when `gray_in_valid`=0.
  - No backpressure: every valid input yields exactly one valid output.
- **Arithmetic.** All arithmetic is unsigned modulo 2^`WIDTH`. No saturation and no overflow outputs beyond `wrap`.

## Timing

- Counter latency is 1 cycle: inputs sampled at edge N appear on `bin_out`/`gray_out`/`wrap` after edge N.
- Decode latency is 1 cycle: `gray_in`/`gray_in_valid` sampled at edge N give `bin_dec`/`bin_dec_valid` after edge N. Full throughput, one decode per cycle.
- `load` and `en` asserted together: the load applies and no count step occurs that cycle.
- Toggling `up` between cycles takes effect on the next enabled edge, with no bubble.
- Deasserting `rst` means the first counting edge is the first edge with `rst`=0.
- All outputs are flop-driven; no combinational input-to-output path.

## Structure

- **Shared package `gray_pkg`:**
  - function `bin_to_gray(bin)`: parametrised-width XOR-shift.
  - function `gray_to_bin(gray)`: prefix-XOR loop, MSB downward.
  
  Both are reused by any later FIFO-pointer block.
- **Sub-module `gray2bin_decode`** (combinational, `WIDTH` parameter) implements the prefix-XOR chain. `gray_counter` instantiates it for the decode channel and registers its output.
- Counter next-state and encode logic stays in the top module.

## Test plan

- **Reset then count.** `WIDTH`=4, `rst`=1 for 2 cycles, then `en`=1, `up`=1 for 16 cycles:
  - outputs are 0 during reset;
  - `bin_out` steps 0→15→0;
  - `gray_out` after 5 counts = 0x7; after 15 counts = 0x8;
  - `wrap`=1 exactly in the cycle `bin_out` returns to 0;
  - every step changes exactly one `gray_out` bit.
- **Down wrap.** From 0 with `en`=1, `up`=0: next `bin_out`=15, `gray_out`=0x8, `wrap`=1. The following cycle gives 14/0x9 with `wrap`=0.
- **Load priority.** `load`=1, `load_bin`=10, `en`=1, `up`=1 → next `bin_out`=10, `gray_out`=0xF, `wrap`=0. Load `load_bin`=0 from 15: `wrap` stays 0.
- **Hold.** `en`=0, `load`=0 for 3 cycles → `bin_out`/`gray_out` unchanged, `wrap`=0.
- **Decode stream.** `gray_in` = 0xC, 0x7, 0x8 on consecutive cycles with `gray_in_valid`=1, then 0 → `bin_dec` = 8, 5, 15 one cycle later with `bin_dec_valid`=1, then `bin_dec_valid`=0 and `bin_dec` holding 15.
- **Reset mid-operation / width sweep.** Assert `rst` while counting at 9 and while `bin_dec_valid`=1 → all outputs 0 after the next edge. Repeat the full up-count with `WIDTH`=8: 256 steps, with one-bit Gray changes and a single `wrap`.
